wsat_clause_scheduler: RTL and testbench
========================================

# wsat_clause_scheduler

Sequences a full clause scan through the two-port WalkSAT clause evaluator. Streams clause words from clause memory, aligns literal addresses and negation bits with the one-cycle variable-table read latency, and collects broken-clause indices into a small FIFO. Arbitrates the shared variable-table address port between scan reads and variable-flip writes.

## Interface
- `CLAUSE_AW`, default 11: clause memory address width.
- `VAR_AW`, default 11: variable address width.
- `FIFO_DEPTH`, default 8: broken-clause FIFO entries, power of 2.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: start a scan. Sampled only in IDLE.
- `num_clauses` input, 12 bits: clause count, 0..2048. Latched on `start`.
- `clause_rd` output, 1 bit: clause memory read strobe.
- `clause_addr` output, CLAUSE_AW bits: clause memory read address.
- `clause_data` input, 36 bits: {neg3, neg2, neg1, addr3, addr2, addr1}. Valid 1 cycle after `clause_rd`.
- `ev_var_address1`, `ev_var_address2` outputs, VAR_AW bits each: variable-table addresses.
- `ev_write` output, 1 bit: variable-table write enable.
- `ev_flip_value` output, 1 bit: write data.
- `ev_valid` output, 1 bit: evaluator valid.
- `ev_neg_bit1`, `ev_neg_bit2` outputs, 1 bit each: literal negations, aligned with `ev_valid`.
- `ev_brk` input, 1 bit: evaluator broken flag. Combinational in the `ev_valid` cycle.
- `flip_req` input, 1 bit: flip request. Held until `flip_ack`.
- `flip_var_address` input, VAR_AW bits: variable to write.
- `flip_value` input, 1 bit: new variable value.
- `flip_ack` output, 1 bit: one-cycle pulse in the write cycle.
- `bc_valid` output, 1 bit: broken-clause FIFO not empty.
- `bc_ready` input, 1 bit: FIFO pop.
- `bc_index` output, 12 bits: broken clause index, FIFO head.
- `busy` output, 1 bit: high in any state other than IDLE.
- `done` output, 1 bit: one-cycle pulse at scan end.
- `broken_count` output, 12 bits: broken clauses found in the current or last scan.

## Operation
- States: IDLE, SCAN, DRAIN, FLIP, FLUSH, DONE.
- Pipeline stages:
  - P0: `clause_rd` is issued with address i.
  - P1: `clause_data` arrives. It drives `ev_var_address1/2` from addr1/addr2, and neg bits and index are registered.
  - P2: `ev_valid`=1 with the registered neg bits. `ev_brk` is sampled.
- If `ev_brk`=1 in P2, push index i into the FIFO and increment `broken_count`.
- IDLE:
  - `start` with `num_clauses`>0 → SCAN. This clears `broken_count` and sets i=0.
  - `start` with `num_clauses`=0 → DONE.
  - `flip_req` → FLIP.
- SCAN:
  - Issue one read per cycle while i<`num_clauses`, then increment i.
  - Stall (no issue) while FIFO free entries < in-flight P1/P2 entries + 1. The FIFO therefore never overflows.
  - `flip_req` → DRAIN.
  - Last index issued → FLUSH.
- DRAIN: no issue. Go to FLIP when P1 and P2 are empty.
- FLIP (1 cycle):
  - `ev_var_address1/2`=`flip_var_address`, `ev_write`=1, `ev_flip_value`=`flip_value`, `flip_ack`=1.
  - `ev_valid`=0.
  - Then return to SCAN if the scan is unfinished, else IDLE.
- FLUSH: wait until P1 and P2 are empty, then → DONE.
- DONE (1 cycle): `done`=1, then → IDLE.
- Clauses issued before a flip see the old value; clauses issued after see the new value. A flip never lands between P1 and P2 of one clause.
- FIFO:
  - A simultaneous push and pop on a full FIFO is legal; count is unchanged.
  - A pop on an empty FIFO is ignored.
  - The FIFO is not cleared on `start`.
- addr3/neg3 are not used for evaluation. Third-literal evaluation is outside this block.

## Timing
- Reset values: state IDLE. All outputs 0: `clause_rd`, `clause_addr`, `ev_*`, `flip_ack`, `bc_valid`, `bc_index`, `busy`, `done`, `broken_count`. FIFO empty.
- Latency: `clause_rd` at cycle n → `ev_valid` at n+2 → FIFO push visible as `bc_valid` at n+3.
- Throughput is 1 clause/cycle when not stalled. Scan of N clauses with no stall or flip: `done` at cycle N+3 after the `start` cycle.
- Flip during SCAN: `flip_ack` arrives at most 3 cycles after `flip_req` is sampled.
- Reset asserted mid-scan: immediately abandon the scan, empty the FIFO, and zero all outputs. No `done` is produced.

## Configuration
- `WSAT_SCHED_STATS_EN` defined: adds output `scan_cycles` (16 bits). It counts cycles from the `start` cycle to `done` inclusive, saturates at 0xFFFF, clears on `start`, and holds after `done`. Reset value 0.
- `WSAT_SCHED_STATS_EN` undefined: port and counter absent. All other behaviour is identical.

## Test plan
- Reset, then `start` with `num_clauses`=0 → `done` one cycle after IDLE exit. `broken_count`=0, `bc_valid`=0.
- `num_clauses`=4, clause 2 forced broken, `bc_ready`=1 → `done` at start+7. `broken_count`=1, single `bc_index`=2.
- `num_clauses`=16, all broken, `bc_ready`=0 → issue stalls with FIFO at 8 entries, no loss. Releasing `bc_ready` pops indices 0..15 in order. `broken_count`=16.
- `flip_req` (address 5, value 1) at scan cycle 3 → no `ev_valid` during FLIP. `flip_ack` within 3 cycles with `ev_var_address1`=5, `ev_write`=1. Scan resumes at the next unissued index; `done` is delayed by the drain plus flip cycles.
- `rst` low at mid-scan cycle 5 → all outputs 0 asynchronously. Next `start` runs a clean scan.
- With `WSAT_SCHED_STATS_EN`: `num_clauses`=4, no stalls → `scan_cycles`=8 at `done`.

Source files
------------

// File: rtl/wsat_clause_scheduler.sv
// WalkSAT clause-scan sequencer: streams clause words, aligns literal reads with the variable table,
// queues broken-clause indices and shares the variable-table port with flips. Option: WSAT_SCHED_STATS_EN.
module wsat_clause_scheduler #(
  parameter int CLAUSE_AW  = 11,
  parameter int VAR_AW     = 11,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [11:0]          num_clauses,
  output logic                 clause_rd,
  output logic [CLAUSE_AW-1:0] clause_addr,
  input  logic [35:0]          clause_data,
  output logic [VAR_AW-1:0]    ev_var_address1,
  output logic [VAR_AW-1:0]    ev_var_address2,
  output logic                 ev_write,
  output logic                 ev_flip_value,
  output logic                 ev_valid,
  output logic                 ev_neg_bit1,
  output logic                 ev_neg_bit2,
  input  logic                 ev_brk,
  input  logic                 flip_req,
  input  logic [VAR_AW-1:0]    flip_var_address,
  input  logic                 flip_value,
  output logic                 flip_ack,
  output logic                 bc_valid,
  input  logic                 bc_ready,
  output logic [11:0]          bc_index,
  output logic                 busy,
  output logic                 done,
  output logic [11:0]          broken_count
`ifdef WSAT_SCHED_STATS_EN
  ,
  output logic [15:0]          scan_cycles
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;
  localparam int FW = 11;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_FLIP, S_FLUSH, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [11:0]    idx_q, idx_d;
  logic [11:0]    num_q, num_d;
  logic           p1_valid_q, p1_valid_d;
  logic [11:0]    p1_idx_q, p1_idx_d;
  logic           p2_valid_q, p2_valid_d;
  logic [11:0]    p2_idx_q, p2_idx_d;
  logic           p2_neg1_q, p2_neg1_d;
  logic           p2_neg2_q, p2_neg2_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [11:0]    brk_cnt_q, brk_cnt_d;
  logic [11:0]    fifo_mem_q [FIFO_DEPTH];

  logic           issue, push, pop, room;
  logic [OW-1:0]  occ;
  logic           unused_bits;

  always_comb begin
    unused_bits = ^{clause_data[35], clause_data[32:22]};
  end

  // Reserve a FIFO slot for every clause still in P1/P2 plus the one about to issue.
  always_comb begin
    occ  = OW'(cnt_q) + OW'(p1_valid_q) + OW'(p2_valid_q) + OW'(1);
    room = (occ <= OW'(FIFO_DEPTH));
    push = p2_valid_q & ev_brk;
    pop  = bc_ready & (cnt_q != '0);
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    num_d         = num_q;
    issue         = 1'b0;
    flip_ack      = 1'b0;
    ev_write      = 1'b0;
    ev_flip_value = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d   = num_clauses;
          idx_d   = '0;
          state_d = (num_clauses != '0) ? S_SCAN : S_DONE;
        end else if (flip_req) begin
          state_d = S_FLIP;
        end
      end
      S_SCAN: begin
        if (flip_req) begin
          state_d = S_DRAIN;
        end else if (room) begin
          issue = 1'b1;
          idx_d = idx_q + 12'd1;
          if (idx_q + 12'd1 == num_q) state_d = S_FLUSH;
        end
      end
      // P2 always retires in the current cycle, so an empty P1 means an empty pipe next cycle.
      S_DRAIN: if (!p1_valid_q) state_d = S_FLIP;
      S_FLIP: begin
        flip_ack      = 1'b1;
        ev_write      = 1'b1;
        ev_flip_value = flip_value;
        state_d       = (idx_q < num_q) ? S_SCAN : S_IDLE;
      end
      S_FLUSH: if (!p1_valid_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    p1_valid_d = issue;
    p1_idx_d   = idx_q;
    p2_valid_d = p1_valid_q;
    p2_idx_d   = p1_idx_q;
    p2_neg1_d  = clause_data[33];
    p2_neg2_d  = clause_data[34];
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    brk_cnt_d  = brk_cnt_q;
    if (state_q == S_IDLE && start) brk_cnt_d = '0;
    else if (push)                  brk_cnt_d = brk_cnt_q + 12'd1;
  end

  always_comb begin
    ev_var_address1 = '0;
    ev_var_address2 = '0;
    if (state_q == S_FLIP) begin
      ev_var_address1 = flip_var_address;
      ev_var_address2 = flip_var_address;
    end else if (p1_valid_q) begin
      ev_var_address1 = VAR_AW'(clause_data[FW-1:0]);
      ev_var_address2 = VAR_AW'(clause_data[2*FW-1:FW]);
    end
    clause_rd    = issue;
    clause_addr  = issue ? idx_q[CLAUSE_AW-1:0] : '0;
    ev_valid     = p2_valid_q;
    ev_neg_bit1  = p2_valid_q & p2_neg1_q;
    ev_neg_bit2  = p2_valid_q & p2_neg2_q;
    bc_valid     = (cnt_q != '0);
    bc_index     = bc_valid ? fifo_mem_q[rd_ptr_q] : '0;
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    broken_count = brk_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      num_q      <= '0;
      p1_valid_q <= 1'b0;
      p1_idx_q   <= '0;
      p2_valid_q <= 1'b0;
      p2_idx_q   <= '0;
      p2_neg1_q  <= 1'b0;
      p2_neg2_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      brk_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      num_q      <= num_d;
      p1_valid_q <= p1_valid_d;
      p1_idx_q   <= p1_idx_d;
      p2_valid_q <= p2_valid_d;
      p2_idx_q   <= p2_idx_d;
      p2_neg1_q  <= p2_neg1_d;
      p2_neg2_q  <= p2_neg2_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      brk_cnt_q  <= brk_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= p2_idx_q;
  end

`ifdef WSAT_SCHED_STATS_EN
  logic [15:0] sc_q, sc_d;
  logic        run_q, run_d;

  // The registered count lags one cycle; the DONE cycle adds itself to report an inclusive total.
  always_comb begin
    sc_d  = sc_q;
    run_d = run_q;
    if (state_q == S_IDLE && start) begin
      sc_d  = 16'd1;
      run_d = 1'b1;
    end else if (run_q && sc_q != 16'hFFFF) begin
      sc_d = sc_q + 16'd1;
    end
    if (state_q == S_DONE) run_d = 1'b0;
    scan_cycles = (state_q == S_DONE && sc_q != 16'hFFFF) ? sc_q + 16'd1 : sc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc_q  <= '0;
      run_q <= 1'b0;
    end else begin
      sc_q  <= sc_d;
      run_q <= run_d;
    end
  end
`endif

endmodule

// File: tb/tb_wsat_clause_scheduler.sv
// Directed bench for wsat_clause_scheduler with a clause-memory model and a 2-literal evaluator model.
module tb_wsat_clause_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] num_clauses;
  logic        clause_rd;
  logic [10:0] clause_addr;
  logic [35:0] clause_data = '0;
  logic [10:0] ev_var_address1, ev_var_address2;
  logic        ev_write, ev_flip_value, ev_valid, ev_neg_bit1, ev_neg_bit2;
  logic        ev_brk;
  logic        flip_req;
  logic [10:0] flip_var_address;
  logic        flip_value;
  logic        flip_ack;
  logic        bc_valid, bc_ready;
  logic [11:0] bc_index;
  logic        busy, done;
  logic [11:0] broken_count;
`ifdef WSAT_SCHED_STATS_EN
  logic [15:0] scan_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wsat_clause_scheduler #(.CLAUSE_AW(11), .VAR_AW(11), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_clauses(num_clauses),
    .clause_rd(clause_rd), .clause_addr(clause_addr), .clause_data(clause_data),
    .ev_var_address1(ev_var_address1), .ev_var_address2(ev_var_address2),
    .ev_write(ev_write), .ev_flip_value(ev_flip_value), .ev_valid(ev_valid),
    .ev_neg_bit1(ev_neg_bit1), .ev_neg_bit2(ev_neg_bit2), .ev_brk(ev_brk),
    .flip_req(flip_req), .flip_var_address(flip_var_address), .flip_value(flip_value),
    .flip_ack(flip_ack), .bc_valid(bc_valid), .bc_ready(bc_ready), .bc_index(bc_index),
    .busy(busy), .done(done), .broken_count(broken_count)
`ifdef WSAT_SCHED_STATS_EN
    , .scan_cycles(scan_cycles)
`endif
  );

  // Clause memory: one-cycle read latency.
  logic [35:0] cmem [0:31];
  always @(posedge clk) if (clause_rd) clause_data <= cmem[clause_addr[4:0]];

  // Variable table: one-cycle read latency, written through port 1.
  logic vt [0:2047];
  logic v1_q, v2_q;
  logic vt_clr = 1'b0;
  always @(posedge clk) begin
    if (vt_clr) begin
      for (int k = 0; k < 2048; k++) vt[k] <= 1'b0;
    end else begin
      v1_q <= vt[ev_var_address1];
      v2_q <= vt[ev_var_address2];
      if (ev_write) vt[ev_var_address1] <= ev_flip_value;
    end
  end
  always_comb ev_brk = ev_valid & ~((v1_q ^ ev_neg_bit1) | (v2_q ^ ev_neg_bit2));

  logic [66:0] all_out;
  always_comb all_out = {clause_rd, clause_addr, ev_var_address1, ev_var_address2, ev_write,
                         ev_flip_value, ev_valid, ev_neg_bit1, ev_neg_bit2, flip_ack, bc_valid,
                         bc_index, busy, done, broken_count};

  function automatic logic [35:0] mkc(input logic [10:0] a1, input logic [10:0] a2,
                                      input logic n1, input logic n2);
    return {1'b1, n2, n1, 11'h7FF, a2, a1};
  endfunction

  task automatic clear_vt();
    @(negedge clk);
    vt_clr = 1'b1;
    @(posedge clk);
    #1 vt_clr = 1'b0;
  endtask

  // Leaves the bench just after the edge that sampled start, i.e. early in scan cycle 1.
  task automatic start_scan(input logic [11:0] n);
    @(negedge clk);
    num_clauses = n;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if (all_out !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got %h want 0", all_out);
    end
`ifdef WSAT_SCHED_STATS_EN
    n_vec++;
    if (scan_cycles !== 16'd0) begin
      n_err++;
      $display("FAIL reset_scan_cycles got %0d want 0", scan_cycles);
    end
`endif
  endtask

  task automatic test_zero_clauses();
    start_scan(12'd0);
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL zero_done got done=%b busy=%b want 1 1", done, busy);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_idle got done=%b busy=%b want 0 0", done, busy);
    end
    n_vec++;
    if (broken_count !== 12'd0 || bc_valid !== 1'b0) begin
      n_err++;
      $display("FAIL zero_result got cnt=%0d bc_valid=%b want 0 0", broken_count, bc_valid);
    end
  endtask

  task automatic test_single_broken(input string tag);
    int done_cyc = 0;
    int first_pop = 0;
    int np = 0;
    logic [11:0] pop0 = '0;
    logic exp_rd, exp_v;
    for (int i = 0; i < 4; i++) cmem[i] = (i == 2) ? mkc(11'd1, 11'd2, 1'b0, 1'b0)
                                                    : mkc(11'd1, 11'd2, 1'b1, 1'b1);
    clear_vt();
    bc_ready = 1'b1;
    start_scan(12'd4);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc <= 8) begin
        exp_rd = (cyc >= 1 && cyc <= 4);
        n_vec++;
        if (clause_rd !== exp_rd) begin
          n_err++;
          $display("FAIL %s clause_rd c%0d got %b want %b", tag, cyc, clause_rd, exp_rd);
        end
        if (exp_rd) begin
          n_vec++;
          if (clause_addr !== 11'(cyc - 1)) begin
            n_err++;
            $display("FAIL %s clause_addr c%0d got %0d want %0d", tag, cyc, clause_addr, cyc - 1);
          end
        end
        exp_v = (cyc >= 3 && cyc <= 6);
        n_vec++;
        if (ev_valid !== exp_v) begin
          n_err++;
          $display("FAIL %s ev_valid c%0d got %b want %b", tag, cyc, ev_valid, exp_v);
        end
        if (exp_v) begin
          n_vec++;
          if (ev_neg_bit1 !== (cyc != 5)) begin
            n_err++;
            $display("FAIL %s ev_neg_bit1 c%0d got %b want %b", tag, cyc, ev_neg_bit1, cyc != 5);
          end
        end
      end
      if (bc_valid && bc_ready) begin
        if (np == 0) begin
          first_pop = cyc;
          pop0 = bc_index;
        end
        np++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    n_vec++;
    if (done_cyc != 7) begin
      n_err++;
      $display("FAIL %s done_cycle got %0d want 7", tag, done_cyc);
    end
    n_vec++;
    if (np != 1 || pop0 !== 12'd2) begin
      n_err++;
      $display("FAIL %s pops got n=%0d idx=%0d want n=1 idx=2", tag, np, pop0);
    end
    n_vec++;
    if (first_pop != 6) begin
      n_err++;
      $display("FAIL %s bc_valid_cycle got %0d want 6", tag, first_pop);
    end
    n_vec++;
    if (broken_count !== 12'd1) begin
      n_err++;
      $display("FAIL %s broken_count got %0d want 1", tag, broken_count);
    end
    @(negedge clk);
    bc_ready = 1'b0;
  endtask

  task automatic test_fifo_stall();
    int nissue = 0;
    int np = 0;
    logic seen_done = 1'b0;
    logic [11:0] pops [0:31];
    for (int i = 0; i < 16; i++) cmem[i] = mkc(11'd1, 11'd2, 1'b0, 1'b0);
    clear_vt();
    bc_ready = 1'b0;
    start_scan(12'd16);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (clause_rd) begin
        n_vec++;
        if (clause_addr !== 11'(nissue)) begin
          n_err++;
          $display("FAIL stall_issue_addr got %0d want %0d", clause_addr, nissue);
        end
        nissue++;
      end
      if (done) seen_done = 1'b1;
    end
    n_vec++;
    if (nissue != 8 || seen_done) begin
      n_err++;
      $display("FAIL stall_hold got issued=%0d done=%b want 8 0", nissue, seen_done);
    end
    n_vec++;
    if (bc_valid !== 1'b1 || broken_count !== 12'd8 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL stall_state got bc_valid=%b cnt=%0d busy=%b want 1 8 1",
               bc_valid, broken_count, busy);
    end
    bc_ready = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (bc_valid && bc_ready && np < 32) begin
        pops[np] = bc_index;
        np++;
      end
      if (clause_rd) nissue++;
      if (done) seen_done = 1'b1;
      if (seen_done && np >= 16 && !bc_valid) break;
      @(negedge clk);
    end
    n_vec++;
    if (np != 16 || nissue != 16 || !seen_done) begin
      n_err++;
      $display("FAIL stall_drain got pops=%0d issued=%0d done=%b want 16 16 1", np, nissue, seen_done);
    end
    for (int k = 0; k < 16 && k < np; k++) begin
      n_vec++;
      if (pops[k] !== 12'(k)) begin
        n_err++;
        $display("FAIL stall_order[%0d] got %0d want %0d", k, pops[k], k);
      end
    end
    n_vec++;
    if (broken_count !== 12'd16) begin
      n_err++;
      $display("FAIL stall_broken_count got %0d want 16", broken_count);
    end
    bc_ready = 1'b0;
  endtask

  task automatic test_flip();
    int ack_cyc = 0;
    int done_cyc = 0;
    int after_cyc = 0;
    int nwrite = 0;
    int np = 0;
    logic [10:0] after_addr = '0;
    logic [11:0] pops [0:7];
    for (int i = 0; i < 8; i++) cmem[i] = mkc(11'd5, 11'd5, 1'b0, 1'b0);
    clear_vt();
    bc_ready = 1'b1;
    flip_var_address = 11'd5;
    flip_value = 1'b1;
    start_scan(12'd8);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 3) flip_req = 1'b1;
      #1;
      if (clause_rd && ack_cyc > 0 && after_cyc == 0) begin
        after_cyc = cyc;
        after_addr = clause_addr;
      end
      if (ev_write) nwrite++;
      if (flip_ack) begin
        if (ack_cyc == 0) ack_cyc = cyc;
        n_vec++;
        if (ev_var_address1 !== 11'd5 || ev_var_address2 !== 11'd5 || ev_write !== 1'b1 ||
            ev_flip_value !== 1'b1 || ev_valid !== 1'b0) begin
          n_err++;
          $display("FAIL flip_cycle got a1=%0d a2=%0d wr=%b val=%b ev_valid=%b want 5 5 1 1 0",
                   ev_var_address1, ev_var_address2, ev_write, ev_flip_value, ev_valid);
        end
        flip_req = 1'b0;
      end
      if (bc_valid && bc_ready && np < 8) begin
        pops[np] = bc_index;
        np++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    flip_req = 1'b0;
    n_vec++;
    if (ack_cyc < 4 || ack_cyc > 6) begin
      n_err++;
      $display("FAIL flip_ack_latency got cycle %0d want 4..6", ack_cyc);
    end
    n_vec++;
    if (nwrite != 1) begin
      n_err++;
      $display("FAIL flip_write_count got %0d want 1", nwrite);
    end
    n_vec++;
    if (after_addr !== 11'd2 || after_cyc != ack_cyc + 1) begin
      n_err++;
      $display("FAIL flip_resume got addr=%0d cyc=%0d want addr=2 cyc=%0d", after_addr, after_cyc, ack_cyc + 1);
    end
    n_vec++;
    if (done_cyc != ack_cyc + 9) begin
      n_err++;
      $display("FAIL flip_done_cycle got %0d want %0d", done_cyc, ack_cyc + 9);
    end
    n_vec++;
    if (broken_count !== 12'd2 || np != 2 || pops[0] !== 12'd0 || pops[1] !== 12'd1) begin
      n_err++;
      $display("FAIL flip_broken got cnt=%0d pops=%0d want cnt=2 pops=2 (0,1)", broken_count, np);
    end
    @(negedge clk);
    bc_ready = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    for (int i = 0; i < 16; i++) cmem[i] = mkc(11'd1, 11'd2, 1'b0, 1'b0);
    clear_vt();
    bc_ready = 1'b0;
    start_scan(12'd16);
    for (int cyc = 1; cyc <= 5; cyc++) @(negedge clk);
    n_vec++;
    if (bc_valid !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre got bc_valid=%b busy=%b want 1 1", bc_valid, busy);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (all_out !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs got %h want 0", all_out);
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || bc_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_hold got done=%b bc_valid=%b want 0 0", done, bc_valid);
      end
    end
    rst = 1'b1;
    test_single_broken("after_rst");
  endtask

`ifdef WSAT_SCHED_STATS_EN
  task automatic test_stats();
    int done_cyc = 0;
    for (int i = 0; i < 4; i++) cmem[i] = mkc(11'd1, 11'd2, 1'b1, 1'b1);
    clear_vt();
    bc_ready = 1'b1;
    start_scan(12'd4);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_cyc = cyc;
        n_vec++;
        if (scan_cycles !== 16'd8) begin
          n_err++;
          $display("FAIL stats_at_done got %0d want 8", scan_cycles);
        end
        break;
      end
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (done_cyc != 7 || scan_cycles !== 16'd8) begin
      n_err++;
      $display("FAIL stats_hold got done_cyc=%0d cycles=%0d want 7 8", done_cyc, scan_cycles);
    end
    bc_ready = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b0;
    start = 1'b0;
    num_clauses = '0;
    flip_req = 1'b0;
    flip_var_address = '0;
    flip_value = 1'b0;
    bc_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    test_zero_clauses();
    test_single_broken("single");
    test_fifo_stall();
    test_flip();
    test_reset_mid_scan();
`ifdef WSAT_SCHED_STATS_EN
    test_stats();
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
